// File: rtl/spi_slave_framer_if.sv
// Buffer-side bus of the SPI framer: receive-buffer write strobe/data and
// transmit-buffer advance strobe/current word.
interface spi_slave_framer_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                  rx_action;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  tx_action;
    logic [DATA_WIDTH-1:0] tx_data;

    // master: the framer; slave: the attached word buffers
    modport master (
        output rx_action,
        output rx_data,
        output tx_action,
        input  tx_data
    );

    modport slave (
        input  rx_action,
        input  rx_data,
        input  tx_action,
        output tx_data
    );
endinterface

// File: rtl/spi_slave_framer.sv
// SPI mode-0 slave framer: oversamples sclk/mosi/cs_n in the clk domain,
// assembles MSB-first words and serialises the transmit buffer onto miso.
module spi_slave_framer #(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sclk,
    input  logic                 mosi,
    input  logic                 cs_n,
    output logic                 miso,
    output logic                 spi_active,
    output logic [CNT_WIDTH-1:0] words_received,
    output logic                 frame_err,
    spi_slave_framer_if.master   buf_if
);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t                  state_reg;
    logic [SYNC_STAGES-1:0][2:0] sync_reg;
    logic                    sclk_d_reg;
    logic                    cs_d_reg;
    logic [BW-1:0]           bit_cnt_reg;
    logic                    word_seen_reg;
    logic [DATA_WIDTH-2:0]   rx_shift_reg;
    logic [DATA_WIDTH-2:0]   tx_shift_reg;
    logic [DATA_WIDTH-1:0]   rx_data_reg;
    logic                    rx_action_reg;
    logic                    tx_action_reg;
    logic                    miso_reg;
    logic                    spi_active_reg;
    logic                    frame_err_reg;
    logic [CNT_WIDTH-1:0]    words_reg;

    logic          s_sclk, s_mosi, s_cs;
    logic          sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic          word_last;
    logic [BW-1:0] bit_cnt_next;

    // Sync flops reset to 0 so a cs_n held low across reset never looks like a
    // falling edge; the master must deassert and reassert it to start a frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_reg   <= '0;
            sclk_d_reg <= 1'b0;
            cs_d_reg   <= 1'b0;
        end else begin
            sync_reg   <= {sync_reg[SYNC_STAGES-2:0], sclk, mosi, cs_n};
            sclk_d_reg <= s_sclk;
            cs_d_reg   <= s_cs;
        end
    end

    assign s_sclk = sync_reg[SYNC_STAGES-1][2];
    assign s_mosi = sync_reg[SYNC_STAGES-1][1];
    assign s_cs   = sync_reg[SYNC_STAGES-1][0];

    assign sclk_rise = s_sclk & ~sclk_d_reg;
    assign sclk_fall = ~s_sclk & sclk_d_reg;
    assign cs_rise   = s_cs & ~cs_d_reg;
    assign cs_fall   = ~s_cs & cs_d_reg;

    assign word_last    = (bit_cnt_reg == LAST_BIT);
    // Counter value after this cycle's sclk edge, so a cs_n rise coinciding
    // with a completing edge sees the wrapped count and raises no frame_err.
    assign bit_cnt_next = sclk_rise ? (word_last ? '0 : bit_cnt_reg + BW'(1)) : bit_cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            bit_cnt_reg    <= '0;
            word_seen_reg  <= 1'b0;
            rx_shift_reg   <= '0;
            tx_shift_reg   <= '0;
            rx_data_reg    <= '0;
            rx_action_reg  <= 1'b0;
            tx_action_reg  <= 1'b0;
            miso_reg       <= 1'b0;
            spi_active_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            words_reg      <= '0;
        end else begin
            rx_action_reg <= 1'b0;
            tx_action_reg <= 1'b0;
            frame_err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    spi_active_reg <= 1'b0;
                    miso_reg       <= 1'b0;
                    if (cs_fall)
                        state_reg <= LOAD;
                end
                LOAD: begin
                    tx_shift_reg   <= buf_if.tx_data[DATA_WIDTH-2:0];
                    miso_reg       <= buf_if.tx_data[DATA_WIDTH-1];
                    bit_cnt_reg    <= '0;
                    word_seen_reg  <= 1'b0;
                    words_reg      <= '0;
                    spi_active_reg <= 1'b1;
                    state_reg      <= SHIFT;
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        rx_shift_reg <= {rx_shift_reg[DATA_WIDTH-3:0], s_mosi};
                        bit_cnt_reg  <= bit_cnt_next;
                        if (word_last) begin
                            rx_data_reg   <= {rx_shift_reg, s_mosi};
                            rx_action_reg <= 1'b1;
                            tx_action_reg <= 1'b1;
                            word_seen_reg <= 1'b1;
                            if (words_reg != '1)
                                words_reg <= words_reg + CNT_WIDTH'(1);
                        end
                    end else if (sclk_fall) begin
                        // The buffer has advanced by now, so tx_data is the next word.
                        if (bit_cnt_reg == '0 && word_seen_reg) begin
                            tx_shift_reg <= buf_if.tx_data[DATA_WIDTH-2:0];
                            miso_reg     <= buf_if.tx_data[DATA_WIDTH-1];
                        end else begin
                            tx_shift_reg <= {tx_shift_reg[DATA_WIDTH-3:0], 1'b0};
                            miso_reg     <= tx_shift_reg[DATA_WIDTH-2];
                        end
                    end
                    if (cs_rise) begin
                        state_reg      <= DONE;
                        spi_active_reg <= 1'b0;
                        miso_reg       <= 1'b0;
                        if (bit_cnt_next != '0)
                            frame_err_reg <= 1'b1;
                    end
                end
                DONE: begin
                    spi_active_reg <= 1'b0;
                    miso_reg       <= 1'b0;
                    state_reg      <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign miso             = miso_reg;
    assign spi_active       = spi_active_reg;
    assign words_received   = words_reg;
    assign frame_err        = frame_err_reg;
    assign buf_if.rx_action = rx_action_reg;
    assign buf_if.rx_data   = rx_data_reg;
    assign buf_if.tx_action = tx_action_reg;
endmodule

// File: tb/tb_spi_slave_framer.sv
// Directed bench for spi_slave_framer: a bit-banged SPI master, a transmit
// buffer model, and a second instance with a 2-bit word counter.
module tb_spi_slave_framer;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sclk = 1'b0;
    logic mosi = 1'b0;
    logic cs_n = 1'b1;

    logic       miso, spi_active, frame_err;
    logic [7:0] words_received;
    logic       miso_sat, spi_active_sat, frame_err_sat;
    logic [1:0] words_received_sat;

    spi_slave_framer_if #(.DATA_WIDTH(DW)) bif ();
    spi_slave_framer_if #(.DATA_WIDTH(DW)) bif_sat ();

    spi_slave_framer #(.DATA_WIDTH(DW), .SYNC_STAGES(2), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
        .miso(miso), .spi_active(spi_active), .words_received(words_received),
        .frame_err(frame_err), .buf_if(bif)
    );

    spi_slave_framer #(.DATA_WIDTH(DW), .SYNC_STAGES(2), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
        .miso(miso_sat), .spi_active(spi_active_sat), .words_received(words_received_sat),
        .frame_err(frame_err_sat), .buf_if(bif_sat)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Transmit buffer model: data_out advances one clk after each tx_action
    logic [DW-1:0] tx_words [8];
    int            tx_count = 0;
    int            tx_base  = 0;
    logic [DW-1:0] tx_q;
    always_comb tx_q = tx_words[(tx_count - tx_base) & 7];
    assign bif.tx_data     = tx_q;
    assign bif_sat.tx_data = tx_q;

    // Monitors
    logic [DW-1:0] rx_log [16];
    int   rx_count = 0, sat_rx_count = 0, err_count = 0;
    logic prev_rx = 1'b0, prev_tx = 1'b0, dbl_pulse = 1'b0;
    always @(posedge clk) begin
        if (bif.tx_action) tx_count <= tx_count + 1;
        if (bif.rx_action) begin
            rx_log[rx_count & 15] <= bif.rx_data;
            rx_count <= rx_count + 1;
        end
        if (bif_sat.rx_action) sat_rx_count <= sat_rx_count + 1;
        if (frame_err) err_count <= err_count + 1;
        prev_rx <= bif.rx_action;
        prev_tx <= bif.tx_action;
        if ((prev_rx && bif.rx_action) || (prev_tx && bif.tx_action)) dbl_pulse <= 1'b1;
    end

    task automatic cs_low();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (5) @(negedge clk);
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Mode 0, MSB first: master samples miso just before each rising edge
    task automatic xfer_bits(input logic [DW-1:0] mo, input int nbits, output logic [DW-1:0] mi);
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[DW-1-i];
            repeat (5) @(negedge clk);
            mi = {mi[DW-2:0], miso};
            sclk = 1'b1;
            repeat (5) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        if (miso !== 1'b0) begin $display("FAIL reset_miso: got %b expected 0", miso); n_fail++; end
        n_tests++;
        if (spi_active !== 1'b0) begin $display("FAIL reset_spi_active: got %b expected 0", spi_active); n_fail++; end
        n_tests++;
        if (bif.rx_action !== 1'b0 || bif.tx_action !== 1'b0) begin
            $display("FAIL reset_strobes: got rx=%b tx=%b expected 0 0", bif.rx_action, bif.tx_action); n_fail++;
        end
        n_tests++;
        if (bif.rx_data !== 32'h0) begin $display("FAIL reset_rx_data: got %h expected 00000000", bif.rx_data); n_fail++; end
        n_tests++;
        if (words_received !== 8'd0 || frame_err !== 1'b0) begin
            $display("FAIL reset_counters: got words=%0d err=%b expected 0 0", words_received, frame_err); n_fail++;
        end
        n_tests++;
        rst = 1'b1;
        repeat (6) @(negedge clk);
        if (spi_active !== 1'b0) begin $display("FAIL reset_idle_after_release: got %b expected 0", spi_active); n_fail++; end
        n_tests++;
    endtask

    task automatic test_single_word();
        logic [DW-1:0] mi;
        int rx0, err0;
        tx_words[0] = 32'h12345678; tx_words[1] = 32'h0;
        tx_base = tx_count; rx0 = rx_count; err0 = err_count;
        cs_low();
        xfer_bits(32'hDEADBEEF, 32, mi);
        cs_high();
        $display("[TB] single: rx=%h miso=%h words=%0d", rx_log[rx0 & 15], mi, words_received);
        if (rx_count - rx0 !== 1) begin $display("FAIL single_rx_count: got %0d expected 1", rx_count - rx0); n_fail++; end
        n_tests++;
        if (rx_log[rx0 & 15] !== 32'hDEADBEEF) begin $display("FAIL single_rx_data: got %h expected deadbeef", rx_log[rx0 & 15]); n_fail++; end
        n_tests++;
        if (mi !== 32'h12345678) begin $display("FAIL single_miso: got %h expected 12345678", mi); n_fail++; end
        n_tests++;
        if (words_received !== 8'd1) begin $display("FAIL single_words: got %0d expected 1", words_received); n_fail++; end
        n_tests++;
        if (err_count - err0 !== 0) begin $display("FAIL single_frame_err: got %0d expected 0", err_count - err0); n_fail++; end
        n_tests++;
        if (spi_active !== 1'b0) begin $display("FAIL single_spi_idle: got %b expected 0", spi_active); n_fail++; end
        n_tests++;
    endtask

    task automatic test_reset_mid_frame();
        logic [DW-1:0] mi;
        int rx0;
        tx_words[0] = 32'hFFFFFFFF; tx_words[1] = 32'h0;
        tx_base = tx_count; rx0 = rx_count;
        cs_low();
        xfer_bits(32'hAAAA5555, 12, mi);
        if (spi_active !== 1'b1) begin $display("FAIL midrst_active_before: got %b expected 1", spi_active); n_fail++; end
        n_tests++;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        $display("[TB] mid-frame reset: active=%b miso=%b", spi_active, miso);
        if (spi_active !== 1'b0 || miso !== 1'b0) begin
            $display("FAIL midrst_outputs: got active=%b miso=%b expected 0 0", spi_active, miso); n_fail++;
        end
        n_tests++;
        if (bif.rx_action !== 1'b0 || bif.tx_action !== 1'b0 || frame_err !== 1'b0) begin
            $display("FAIL midrst_strobes: got rx=%b tx=%b err=%b expected 0", bif.rx_action, bif.tx_action, frame_err); n_fail++;
        end
        n_tests++;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        // Rest of the abandoned word with cs_n still low must be ignored
        xfer_bits(32'h0, 20, mi);
        if (rx_count - rx0 !== 0 || spi_active !== 1'b0) begin
            $display("FAIL midrst_no_strobe: got rx=%0d active=%b expected 0 0", rx_count - rx0, spi_active); n_fail++;
        end
        n_tests++;
        cs_high();
        tx_words[0] = 32'h0F0F0F0F;
        tx_base = tx_count; rx0 = rx_count;
        cs_low();
        xfer_bits(32'hCAFEF00D, 32, mi);
        cs_high();
        $display("[TB] after reset: rx=%h miso=%h", rx_log[rx0 & 15], mi);
        if (rx_count - rx0 !== 1 || rx_log[rx0 & 15] !== 32'hCAFEF00D) begin
            $display("FAIL midrst_recover_rx: got n=%0d data=%h expected 1 cafef00d", rx_count - rx0, rx_log[rx0 & 15]); n_fail++;
        end
        n_tests++;
        if (mi !== 32'h0F0F0F0F) begin $display("FAIL midrst_recover_miso: got %h expected 0f0f0f0f", mi); n_fail++; end
        n_tests++;
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] mo [3];
        logic [DW-1:0] mi [3];
        logic [DW-1:0] t;
        int rx0, err0;
        mo[0] = 32'h00000001; mo[1] = 32'h80000000; mo[2] = 32'hA5A5A5A5;
        tx_words[0] = 32'h11111111; tx_words[1] = 32'h22222222;
        tx_words[2] = 32'h33333333; tx_words[3] = 32'h0;
        tx_base = tx_count; rx0 = rx_count; err0 = err_count;
        cs_low();
        for (int w = 0; w < 3; w++) begin
            xfer_bits(mo[w], 32, t);
            mi[w] = t;
        end
        cs_high();
        for (int w = 0; w < 3; w++) begin
            $display("[TB] burst word %0d: rx=%h miso=%h", w, rx_log[(rx0 + w) & 15], mi[w]);
            if (rx_log[(rx0 + w) & 15] !== mo[w]) begin
                $display("FAIL burst_rx_data%0d: got %h expected %h", w, rx_log[(rx0 + w) & 15], mo[w]); n_fail++;
            end
            n_tests++;
            if (mi[w] !== tx_words[w]) begin
                $display("FAIL burst_miso%0d: got %h expected %h", w, mi[w], tx_words[w]); n_fail++;
            end
            n_tests++;
        end
        if (rx_count - rx0 !== 3 || words_received !== 8'd3) begin
            $display("FAIL burst_counts: got rx=%0d words=%0d expected 3 3", rx_count - rx0, words_received); n_fail++;
        end
        n_tests++;
        if (err_count - err0 !== 0) begin $display("FAIL burst_frame_err: got %0d expected 0", err_count - err0); n_fail++; end
        n_tests++;
    endtask

    task automatic test_partial_frame();
        logic [DW-1:0] mi;
        int rx0, err0, fall_at;
        tx_words[0] = 32'h0;
        tx_base = tx_count; rx0 = rx_count; err0 = err_count;
        cs_low();
        xfer_bits(32'h13579BDF, 20, mi);
        repeat (5) @(negedge clk);
        cs_n = 1'b1;
        fall_at = -1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (fall_at < 0 && spi_active === 1'b0) fall_at = i;
        end
        repeat (4) @(negedge clk);
        $display("[TB] partial: errs=%0d rx=%0d active_fall=%0d", err_count - err0, rx_count - rx0, fall_at);
        if (err_count - err0 !== 1) begin $display("FAIL partial_frame_err: got %0d expected 1", err_count - err0); n_fail++; end
        n_tests++;
        if (rx_count - rx0 !== 0) begin $display("FAIL partial_no_rx: got %0d expected 0", rx_count - rx0); n_fail++; end
        n_tests++;
        if (fall_at < 0 || fall_at > 3) begin $display("FAIL partial_active_fall: got %0d expected 0..3", fall_at); n_fail++; end
        n_tests++;
    endtask

    task automatic test_boundary();
        logic [DW-1:0] mi;
        int rx0, err0;
        tx_words[0] = 32'h0;
        tx_base = tx_count; rx0 = rx_count; err0 = err_count;
        cs_low();
        xfer_bits(32'h76543210, 31, mi);
        mosi = 1'b1;
        repeat (5) @(negedge clk);
        sclk = 1'b1;
        cs_n = 1'b1;
        repeat (10) @(negedge clk);
        sclk = 1'b0;
        repeat (6) @(negedge clk);
        $display("[TB] boundary: rx=%0d data=%h errs=%0d", rx_count - rx0, rx_log[rx0 & 15], err_count - err0);
        if (rx_count - rx0 !== 1 || rx_log[rx0 & 15] !== 32'h76543211) begin
            $display("FAIL boundary_rx: got n=%0d data=%h expected 1 76543211", rx_count - rx0, rx_log[rx0 & 15]); n_fail++;
        end
        n_tests++;
        if (err_count - err0 !== 0) begin $display("FAIL boundary_frame_err: got %0d expected 0", err_count - err0); n_fail++; end
        n_tests++;
    endtask

    task automatic test_saturation();
        logic [DW-1:0] mi;
        int rx0, srx0;
        for (int i = 0; i < 8; i++) tx_words[i] = 32'h0;
        tx_base = tx_count; rx0 = rx_count; srx0 = sat_rx_count;
        cs_low();
        for (int w = 0; w < 5; w++) xfer_bits(32'h01010101 * (w + 1), 32, mi);
        repeat (2) @(negedge clk);
        $display("[TB] saturation: words=%0d sat_words=%0d sat_rx=%0d", words_received, words_received_sat, sat_rx_count - srx0);
        if (words_received_sat !== 2'd3) begin $display("FAIL sat_words: got %0d expected 3", words_received_sat); n_fail++; end
        n_tests++;
        if (sat_rx_count - srx0 !== 5) begin $display("FAIL sat_rx_pulses: got %0d expected 5", sat_rx_count - srx0); n_fail++; end
        n_tests++;
        if (words_received !== 8'd5) begin $display("FAIL sat_wide_words: got %0d expected 5", words_received); n_fail++; end
        n_tests++;
        if (rx_log[(rx0 + 4) & 15] !== 32'h05050505) begin
            $display("FAIL sat_last_data: got %h expected 05050505", rx_log[(rx0 + 4) & 15]); n_fail++;
        end
        n_tests++;
        cs_high();
        if (dbl_pulse !== 1'b0) begin $display("FAIL strobe_single_cycle: got %b expected 0", dbl_pulse); n_fail++; end
        n_tests++;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) tx_words[i] = 32'h0;
        test_reset();
        test_single_word();
        test_reset_mid_frame();
        test_back_to_back();
        test_partial_frame();
        test_boundary();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish before 2ms");
        $fatal(1, "timeout");
    end
endmodule
